computer_player: RTL and testbench

//  Downstream consumer of the 10-bit LFSR stream in the tug-of-war game; acts as the CPU opponent.

---
 rtl/tow_pkg.sv | 14 +
 rtl/computer_player_if.sv | 26 ++
 rtl/rand_stuck_detector.sv | 48 ++++
 rtl/computer_player.sv | 106 ++++++++++
 tb/tb_computer_player.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/tow_pkg.sv
// Shared types and widths for the tug-of-war game.
// Used by the LFSR source and the CPU opponent.
package tow_pkg;

   localparam int RAND_W = 10;
   localparam int CNT_W  = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PRESS = 2'd1,
      COOL  = 2'd2
   } cpu_state_t;

endpackage

// File: rtl/computer_player_if.sv
// Signal bundle between the game core and the CPU opponent.
// The master drives game controls; the slave returns press and status.
interface computer_player_if
   import tow_pkg::*;
   ();

   logic              enable;
   logic [RAND_W-1:0] rand_val;
   logic [RAND_W-2:0] difficulty;
   logic              clr_count;
   logic              press;
   logic              busy;
   logic [CNT_W-1:0]  press_count;
   logic              stuck;

   modport master (
      output enable, rand_val, difficulty, clr_count,
      input  press, busy, press_count, stuck
   );

   modport slave (
      input  enable, rand_val, difficulty, clr_count,
      output press, busy, press_count, stuck
   );

endinterface

// File: rtl/rand_stuck_detector.sv
// Flags a random source whose output stops changing.
// Counts consecutive edges where the sample equals the previous one.
module rand_stuck_detector
   import tow_pkg::*;
#(
   parameter int STUCK_CYCLES = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [RAND_W-1:0] rand_val,
   output logic              stuck
);

   localparam int SW = $clog2(STUCK_CYCLES + 1);
   localparam logic [SW-1:0] SMAX = SW'(STUCK_CYCLES);

   logic [RAND_W-1:0] prev_q, prev_d;
   logic              valid_q, valid_d;
   logic [SW-1:0]     cnt_q, cnt_d;
   logic              stuck_q, stuck_d;

   always_comb begin
      prev_d  = rand_val;
      valid_d = 1'b1;
      cnt_d   = '0;
      if (valid_q && (rand_val == prev_q)) begin
         cnt_d = (cnt_q == SMAX) ? cnt_q : cnt_q + 1'b1;
      end
      stuck_d = (cnt_d >= SMAX);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         prev_q  <= '0;
         valid_q <= 1'b0;
         cnt_q   <= '0;
         stuck_q <= 1'b0;
      end else begin
         prev_q  <= prev_d;
         valid_q <= valid_d;
         cnt_q   <= cnt_d;
         stuck_q <= stuck_d;
      end
   end

   assign stuck = stuck_q;

endmodule

// File: rtl/computer_player.sv
// CPU opponent: presses when the random word falls below the difficulty,
// holds the press, then cools down before deciding again.
module computer_player
   import tow_pkg::*;
#(
   parameter int HOLD_CYCLES  = 2,
   parameter int COOL_CYCLES  = 4,
   parameter int STUCK_CYCLES = 4
) (
   input logic             clk,
   input logic             reset,
   computer_player_if.slave cp
);

   localparam int HW = $clog2(HOLD_CYCLES + 1);
   localparam int CW = $clog2(COOL_CYCLES + 1);
   localparam logic [HW-1:0] HLOAD = HW'(HOLD_CYCLES - 1);
   localparam logic [CW-1:0] CLOAD = CW'(COOL_CYCLES - 1);

   cpu_state_t       state_q, state_d;
   logic [HW-1:0]    hold_q, hold_d;
   logic [CW-1:0]    cool_q, cool_d;
   logic             press_q, press_d;
   logic             busy_q, busy_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             win;

   assign win = ({1'b0, cp.difficulty} > cp.rand_val);

   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      cool_d  = cool_q;
      press_d = press_q;
      cnt_d   = cnt_q;
      if (!cp.enable) begin
         state_d = IDLE;
         hold_d  = '0;
         cool_d  = '0;
         press_d = 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (win) begin
                  state_d = PRESS;
                  hold_d  = HLOAD;
                  press_d = 1'b1;
                  if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
               end
            end
            PRESS: begin
               if (hold_q == '0) begin
                  state_d = COOL;
                  cool_d  = CLOAD;
                  press_d = 1'b0;
               end else begin
                  hold_d = hold_q - 1'b1;
               end
            end
            COOL: begin
               if (cool_q == '0) state_d = IDLE;
               else cool_d = cool_q - 1'b1;
            end
            default: begin
               state_d = IDLE;
               press_d = 1'b0;
            end
         endcase
      end
      // a new round wins over a decision on the same edge
      if (cp.clr_count) cnt_d = '0;
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         hold_q  <= '0;
         cool_q  <= '0;
         press_q <= 1'b0;
         busy_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
         cool_q  <= cool_d;
         press_q <= press_d;
         busy_q  <= busy_d;
         cnt_q   <= cnt_d;
      end
   end

   assign cp.press       = press_q;
   assign cp.busy        = busy_q;
   assign cp.press_count = cnt_q;

   rand_stuck_detector #(
      .STUCK_CYCLES(STUCK_CYCLES)
   ) u_stuck (
      .clk     (clk),
      .reset   (reset),
      .rand_val(cp.rand_val),
      .stuck   (cp.stuck)
   );

endmodule

// File: tb/tb_computer_player.sv
// Bench for the CPU opponent: vector table, directed corners,
// and random traffic against a cycle-budget reference model.
module tb_computer_player;
   import tow_pkg::*;

   localparam int HOLD = 2;
   localparam int COOL = 4;
   localparam int STK  = 4;
   localparam int CMAX = (1 << CNT_W) - 1;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   computer_player_if ifc();

   computer_player #(
      .HOLD_CYCLES (HOLD),
      .COOL_CYCLES (COOL),
      .STUCK_CYCLES(STK)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .cp   (ifc)
   );

   int n_vec = 0;
   int n_bad = 0;

   // model: remaining busy cycles, decision count, recent samples
   int busy_left = 0;
   int m_cnt = 0;
   logic [RAND_W-1:0] hist[$];
   logic [RAND_W-1:0] last_r = '0;

   typedef struct {
      bit                en;
      logic [RAND_W-1:0] r;
      logic [RAND_W-2:0] d;
      bit                clr;
      bit                p;
      bit                b;
      int                c;
      bit                s;
   } vec_t;

   vec_t tbl[8];

   function automatic bit m_stuck();
      if (hist.size() < STK + 1) return 1'b0;
      foreach (hist[i]) if (hist[i] != hist[0]) return 1'b0;
      return 1'b1;
   endfunction

   task automatic chk(input string nm, input logic [31:0] got,
                      input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got %0h exp %0h", nm, got, exp);
      end
   endtask

   task automatic model_edge(input bit en, input logic [RAND_W-1:0] r,
                             input logic [RAND_W-2:0] d, input bit clr);
      hist.push_back(r);
      if (hist.size() > STK + 1) void'(hist.pop_front());
      if (!en) busy_left = 0;
      else if (busy_left > 0) busy_left--;
      else if (int'(d) > int'(r)) begin
         busy_left = HOLD + COOL;
         if (m_cnt < CMAX) m_cnt++;
      end
      if (clr) m_cnt = 0;
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".press"}, 32'(ifc.press), 32'(busy_left > COOL));
      chk({tag, ".busy"}, 32'(ifc.busy), 32'(busy_left > 0));
      chk({tag, ".count"}, 32'(ifc.press_count), 32'(m_cnt));
      chk({tag, ".stuck"}, 32'(ifc.stuck), 32'(m_stuck()));
   endtask

   // entered and left at a falling edge
   task automatic tick(input bit en, input logic [RAND_W-1:0] r,
                       input logic [RAND_W-2:0] d, input bit clr,
                       input string tag);
      ifc.enable     = en;
      ifc.rand_val   = r;
      ifc.difficulty = d;
      ifc.clr_count  = clr;
      last_r         = r;
      @(posedge clk);
      model_edge(en, r, d, clr);
      @(negedge clk);
      check_all(tag);
   endtask

   task automatic do_reset(input string tag);
      #2;
      reset = 1'b0;
      #1;
      chk({tag, ".rst_press"}, 32'(ifc.press), 32'd0);
      chk({tag, ".rst_busy"}, 32'(ifc.busy), 32'd0);
      chk({tag, ".rst_count"}, 32'(ifc.press_count), 32'd0);
      chk({tag, ".rst_stuck"}, 32'(ifc.stuck), 32'd0);
      busy_left = 0;
      m_cnt = 0;
      hist.delete();
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic wait_idle(input string tag);
      for (int k = 0; k < 20 && busy_left > 0; k++)
         tick(1'b1, RAND_W'(k + 100), '0, 1'b0, tag);
   endtask

   initial begin
      ifc.enable     = 1'b0;
      ifc.rand_val   = '0;
      ifc.difficulty = '0;
      ifc.clr_count  = 1'b0;

      tbl[0] = '{1, 10'd50,  9'd100, 0, 1, 1, 1, 0};
      tbl[1] = '{1, 10'd1000, 9'd100, 0, 1, 1, 1, 0};
      tbl[2] = '{1, 10'd999, 9'd100, 0, 0, 1, 1, 0};
      tbl[3] = '{1, 10'd20,  9'd100, 0, 0, 1, 1, 0};
      tbl[4] = '{1, 10'd21,  9'd100, 0, 0, 1, 1, 0};
      tbl[5] = '{1, 10'd22,  9'd100, 0, 0, 1, 1, 0};
      tbl[6] = '{1, 10'd23,  9'd100, 0, 0, 0, 1, 0};
      tbl[7] = '{1, 10'd998, 9'd100, 0, 0, 0, 1, 0};

      @(negedge clk);
      do_reset("init");

      for (int i = 0; i < 8; i++) begin
         tick(tbl[i].en, tbl[i].r, tbl[i].d, tbl[i].clr, "tbl");
         chk($sformatf("tbl%0d.press", i), 32'(ifc.press), 32'(tbl[i].p));
         chk($sformatf("tbl%0d.busy", i), 32'(ifc.busy), 32'(tbl[i].b));
         chk($sformatf("tbl%0d.count", i), 32'(ifc.press_count),
             32'(tbl[i].c));
         chk($sformatf("tbl%0d.stuck", i), 32'(ifc.stuck), 32'(tbl[i].s));
      end

      // reset while pressing
      do_reset("t1pre");
      tick(1'b1, 10'd5, 9'd200, 1'b0, "t1");
      chk("t1.press_up", 32'(ifc.press), 32'd1);
      do_reset("t1");

      // difficulty zero never presses
      for (int i = 0; i < 1024; i++)
         tick(1'b1, RAND_W'(i), '0, 1'b0, "sweep");
      chk("sweep.count", 32'(ifc.press_count), 32'd0);

      // enable drop aborts the press
      do_reset("t4pre");
      tick(1'b1, 10'd3, 9'd10, 1'b0, "t4a");
      chk("t4.press_up", 32'(ifc.press), 32'd1);
      tick(1'b0, 10'd4, 9'd10, 1'b0, "t4b");
      chk("t4.press_dn", 32'(ifc.press), 32'd0);
      chk("t4.busy_dn", 32'(ifc.busy), 32'd0);
      chk("t4.count", 32'(ifc.press_count), 32'd1);

      // stuck source
      do_reset("t5pre");
      for (int i = 0; i < 4; i++) tick(1'b0, 10'h3FF, '0, 1'b0, "t5a");
      chk("t5.not_yet", 32'(ifc.stuck), 32'd0);
      tick(1'b0, 10'h3FF, '0, 1'b0, "t5b");
      chk("t5.stuck", 32'(ifc.stuck), 32'd1);
      tick(1'b0, 10'h3FE, '0, 1'b0, "t5c");
      chk("t5.unstuck", 32'(ifc.stuck), 32'd0);

      // saturation, then clear beats increment
      do_reset("t6pre");
      for (int k = 0; k < 3000 && m_cnt < CMAX; k++)
         tick(1'b1, '0, 9'd1, 1'b0, "t6fill");
      chk("t6.full", 32'(ifc.press_count), 32'(CMAX));
      wait_idle("t6w1");
      tick(1'b1, '0, 9'd1, 1'b0, "t6sat");
      chk("t6.sat", 32'(ifc.press_count), 32'(CMAX));
      chk("t6.sat_press", 32'(ifc.press), 32'd1);
      wait_idle("t6w2");
      tick(1'b1, '0, 9'd1, 1'b1, "t6clr");
      chk("t6.clr", 32'(ifc.press_count), 32'd0);
      chk("t6.clr_press", 32'(ifc.press), 32'd1);

      // random traffic
      do_reset("rndpre");
      for (int i = 0; i < 3000; i++) begin
         logic [RAND_W-1:0] r;
         r = ($urandom_range(0, 3) == 0) ? last_r : RAND_W'($urandom);
         tick($urandom_range(0, 15) != 0, r, (RAND_W-1)'($urandom),
              $urandom_range(0, 63) == 0, "rnd");
         if (i == 1500) do_reset("rndmid");
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
